id_top: RTL and testbench

Instruction-decode stage of the five-stage pipelined RISC-V core, directly downstream of the IF stage and its IF/ID register. Consumes the IF/ID instruction and PC+4, reads the 32×32 register file, generates the immediate and control signals, and detects load-use hazards. Drives `pc_write`/`if_id_write` back to the IF stage and registers everything into the ID/EX pipeline register.

---
 rtl/id_if.sv | 36 +++
 rtl/id_top.sv | 125 ++++++++++++
 tb/tb_id_top.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/id_if.sv
// ID-stage bus: IF/ID inputs, writeback port, IF control back-pressure and
// the ID/EX pipeline register outputs. The slave side is the decode stage.
interface id_if;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pc_write;
  logic        if_id_write;
  logic [31:0] id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic        id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch;
  logic [1:0]  id_ex_alu_op;

  modport master (
    output if_id_pc_plus4, if_id_instr, flush, wb_reg_write, wb_rd, wb_data,
    input  pc_write, if_id_write,
    input  id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
    input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct3, id_ex_funct7b5,
    input  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
    input  id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch, id_ex_alu_op
  );
  modport slave (
    input  if_id_pc_plus4, if_id_instr, flush, wb_reg_write, wb_rd, wb_data,
    output pc_write, if_id_write,
    output id_ex_pc_plus4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
    output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct3, id_ex_funct7b5,
    output id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
    output id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch, id_ex_alu_op
  );
endinterface

// File: rtl/id_top.sv
// RV32 instruction-decode stage: regfile read, immediate/control decode,
// load-use stall detection and the ID/EX pipeline register.
// Optional macro ID_REGFILE_BYPASS_EN: same-cycle writeback is visible to
// the regfile read (write-through); otherwise the old value is read.
module id_top (
  input  logic clk,
  input  logic reset,
  id_if.slave  bus
);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic [31:0] pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch;
    logic [1:0]  alu_op;
  } idex_t;

  logic [31:0] r_rf [1:31];
  idex_t       r_idex;
  idex_t       w_idex;
  logic [31:0] w_ins;
  logic [6:0]  w_op;
  logic [4:0]  w_rs1, w_rs2;
  logic        w_uses_rs2, w_stall;

  assign w_ins = bus.if_id_instr;
  assign w_op  = w_ins[6:0];
  assign w_rs1 = w_ins[19:15];
  assign w_rs2 = w_ins[24:20];

  // Regfile write; x0 is not stored at all
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) r_rf[i] <= '0;
    end else if (bus.wb_reg_write && bus.wb_rd != 5'd0) begin
      r_rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Decode, immediate generation and regfile read for the ID/EX payload
  always_comb begin
    w_idex      = '0;
    w_idex.pc4  = bus.if_id_pc_plus4;
    w_idex.rs1  = w_rs1;
    w_idex.rs2  = w_rs2;
    w_idex.rd   = w_ins[11:7];
    w_idex.f3   = w_ins[14:12];
    w_idex.f7b5 = w_ins[30];
    if (w_rs1 != 5'd0) w_idex.rs1d = r_rf[w_rs1];
    if (w_rs2 != 5'd0) w_idex.rs2d = r_rf[w_rs2];
`ifdef ID_REGFILE_BYPASS_EN
    if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == w_rs1) w_idex.rs1d = bus.wb_data;
    if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == w_rs2) w_idex.rs2d = bus.wb_data;
`endif
    case (w_op)
      OP_R: begin
        w_idex.reg_write = 1'b1;
        w_idex.alu_op    = 2'b10;
      end
      OP_I: begin
        w_idex.reg_write = 1'b1;
        w_idex.alu_src   = 1'b1;
        w_idex.alu_op    = 2'b11;
        w_idex.imm       = {{20{w_ins[31]}}, w_ins[31:20]};
      end
      OP_LD: begin
        w_idex.reg_write  = 1'b1;
        w_idex.mem_read   = 1'b1;
        w_idex.mem_to_reg = 1'b1;
        w_idex.alu_src    = 1'b1;
        w_idex.imm        = {{20{w_ins[31]}}, w_ins[31:20]};
      end
      OP_ST: begin
        w_idex.mem_write = 1'b1;
        w_idex.alu_src   = 1'b1;
        w_idex.imm       = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      end
      OP_BR: begin
        w_idex.branch = 1'b1;
        w_idex.alu_op = 2'b01;
        w_idex.imm    = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // rs2 only matters for formats that actually read it
  assign w_uses_rs2 = (w_op == OP_R) || (w_op == OP_ST) || (w_op == OP_BR);
  assign w_stall    = r_idex.mem_read && (r_idex.rd != 5'd0) &&
                      ((r_idex.rd == w_rs1) || ((r_idex.rd == w_rs2) && w_uses_rs2));

  assign bus.pc_write    = !w_stall;
  assign bus.if_id_write = !w_stall;

  // ID/EX register: bubble on flush or stall, else take the decoded payload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    r_idex <= '0;
    else if (bus.flush || w_stall) r_idex <= '0;
    else                           r_idex <= w_idex;
  end

  assign bus.id_ex_pc_plus4   = r_idex.pc4;
  assign bus.id_ex_rs1_data   = r_idex.rs1d;
  assign bus.id_ex_rs2_data   = r_idex.rs2d;
  assign bus.id_ex_imm        = r_idex.imm;
  assign bus.id_ex_rs1        = r_idex.rs1;
  assign bus.id_ex_rs2        = r_idex.rs2;
  assign bus.id_ex_rd         = r_idex.rd;
  assign bus.id_ex_funct3     = r_idex.f3;
  assign bus.id_ex_funct7b5   = r_idex.f7b5;
  assign bus.id_ex_reg_write  = r_idex.reg_write;
  assign bus.id_ex_mem_read   = r_idex.mem_read;
  assign bus.id_ex_mem_write  = r_idex.mem_write;
  assign bus.id_ex_mem_to_reg = r_idex.mem_to_reg;
  assign bus.id_ex_alu_src    = r_idex.alu_src;
  assign bus.id_ex_branch     = r_idex.branch;
  assign bus.id_ex_alu_op     = r_idex.alu_op;
endmodule

// File: tb/tb_id_top.sv
// Bench for the ID stage: vector table through a scoreboard queue, plus
// hand-written reset and reset-during-stall sequences.
module tb_id_top;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_if bus();
  id_top dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [5:0]  ctl;   // reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch
    logic [1:0]  alu_op;
  } idex_t;

  typedef struct packed {
    logic [31:0] instr, pc4;
    logic        flush, wbe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        stall;
    idex_t       exp;
  } vec_t;

  vec_t  vecs[$];
  idex_t sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  localparam logic [5:0] C_R  = 6'b100000;
  localparam logic [5:0] C_I  = 6'b100010;
  localparam logic [5:0] C_LD = 6'b110110;
  localparam logic [5:0] C_ST = 6'b001010;
  localparam logic [5:0] C_BR = 6'b000001;

  function automatic idex_t ex(input logic [31:0] pc4, rs1d, rs2d, imm,
                               input logic [4:0] rs1, rs2, rd, input logic [2:0] f3,
                               input logic f7b5, input logic [5:0] ctl, input logic [1:0] alu_op);
    ex = {pc4, rs1d, rs2d, imm, rs1, rs2, rd, f3, f7b5, ctl, alu_op};
  endfunction

  function automatic idex_t got();
    got = {bus.id_ex_pc_plus4, bus.id_ex_rs1_data, bus.id_ex_rs2_data, bus.id_ex_imm,
           bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_rd, bus.id_ex_funct3, bus.id_ex_funct7b5,
           bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write,
           bus.id_ex_mem_to_reg, bus.id_ex_alu_src, bus.id_ex_branch, bus.id_ex_alu_op};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic add_vec(input logic [31:0] instr, pc4, input logic flush, wbe,
                         input logic [4:0] wbrd, input logic [31:0] wbd,
                         input logic stall, input idex_t exp);
    vecs.push_back({instr, pc4, flush, wbe, wbrd, wbd, stall, exp});
  endtask

  task automatic drive(input logic [31:0] instr, pc4, input logic flush, wbe,
                       input logic [4:0] wbrd, input logic [31:0] wbd);
    bus.if_id_instr    = instr;
    bus.if_id_pc_plus4 = pc4;
    bus.flush          = flush;
    bus.wb_reg_write   = wbe;
    bus.wb_rd          = wbrd;
    bus.wb_data        = wbd;
  endtask

  // Clock the edge, then pop the oldest expectation and compare
  task automatic edge_and_pop(input string nm);
    idex_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty, got %h want entry", nm, got());
    end else begin
      e = sb.pop_front();
      chk(nm, 160'(got()), 160'(e));
    end
  endtask

  initial begin
    logic [31:0] byp;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_idex", 160'(got()), 160'(0));
    chk("reset_pcw", {158'd0, bus.pc_write, bus.if_id_write}, 160'd3);
    reset = 1'b1;

`ifdef ID_REGFILE_BYPASS_EN
    byp = 32'hA5A5_A5A5;
`else
    byp = 32'h0;
`endif

    // preload x1,x2,x3,x5,x6 while ID sees all-zero (unknown-opcode) words
    add_vec(32'h0, 32'h0, 0, 1, 5'd1, 32'h100,  0, '0);
    add_vec(32'h0, 32'h0, 0, 1, 5'd2, 32'h22,   0, '0);
    add_vec(32'h0, 32'h0, 0, 1, 5'd3, 32'h3000, 0, '0);
    add_vec(32'h0, 32'h0, 0, 1, 5'd5, 32'h1234, 0, '0);
    add_vec(32'h0, 32'h0, 0, 1, 5'd6, 32'h10,   0, '0);
    // add x7,x5,x6
    add_vec(32'h006283B3, 32'h104, 0, 0, 0, 0, 0, ex(32'h104, 32'h1234, 32'h10, 0, 5, 6, 7, 0, 0, C_R, 2'b10));
    // addi x1,x0,-1
    add_vec(32'hFFF00093, 32'h108, 0, 0, 0, 0, 0, ex(32'h108, 0, 0, 32'hFFFF_FFFF, 0, 31, 1, 0, 1, C_I, 2'b11));
    // sw x2,-4(x3)
    add_vec(32'hFE21AE23, 32'h10C, 0, 0, 0, 0, 0, ex(32'h10C, 32'h3000, 32'h22, 32'hFFFF_FFFC, 3, 2, 28, 2, 1, C_ST, 2'b00));
    // beq x1,x2,-8
    add_vec(32'hFE208CE3, 32'h110, 0, 0, 0, 0, 0, ex(32'h110, 32'h100, 32'h22, 32'hFFFF_FFF8, 1, 2, 25, 0, 1, C_BR, 2'b01));
    // lw x5,0(x1) ; add x6,x5,x2 stalls once then issues
    add_vec(32'h0000A283, 32'h114, 0, 0, 0, 0, 0, ex(32'h114, 32'h100, 0, 0, 1, 0, 5, 2, 0, C_LD, 2'b00));
    add_vec(32'h00228333, 32'h118, 0, 0, 0, 0, 1, '0);
    add_vec(32'h00228333, 32'h118, 0, 0, 0, 0, 0, ex(32'h118, 32'h1234, 32'h22, 0, 5, 2, 6, 0, 0, C_R, 2'b10));
    // lw x5 ; addi x8,x1,5 (rs2 field == 5 but I-type ignores it)
    add_vec(32'h0000A283, 32'h11C, 0, 0, 0, 0, 0, ex(32'h11C, 32'h100, 0, 0, 1, 0, 5, 2, 0, C_LD, 2'b00));
    add_vec(32'h00508413, 32'h120, 0, 0, 0, 0, 0, ex(32'h120, 32'h100, 32'h1234, 5, 1, 5, 8, 0, 0, C_I, 2'b11));
    // lw x0 ; add x6,x0,x2 : no stall on x0
    add_vec(32'h0000A003, 32'h124, 0, 0, 0, 0, 0, ex(32'h124, 32'h100, 0, 0, 1, 0, 0, 2, 0, C_LD, 2'b00));
    add_vec(32'h00200333, 32'h128, 0, 0, 0, 0, 0, ex(32'h128, 0, 32'h22, 0, 0, 2, 6, 0, 0, C_R, 2'b10));
    // flush with a valid add
    add_vec(32'h006283B3, 32'h12C, 1, 0, 0, 0, 0, '0);
    // flush together with a stall
    add_vec(32'h0000A283, 32'h130, 0, 0, 0, 0, 0, ex(32'h130, 32'h100, 0, 0, 1, 0, 5, 2, 0, C_LD, 2'b00));
    add_vec(32'h00228333, 32'h134, 1, 0, 0, 0, 1, '0);
    add_vec(32'h00228333, 32'h134, 0, 0, 0, 0, 0, ex(32'h134, 32'h1234, 32'h22, 0, 5, 2, 6, 0, 0, C_R, 2'b10));
    // x0 write attempt then read x0
    add_vec(32'h00000533, 32'h138, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, ex(32'h138, 0, 0, 0, 0, 0, 10, 0, 0, C_R, 2'b10));
    add_vec(32'h00000533, 32'h13C, 0, 0, 0, 0, 0, ex(32'h13C, 0, 0, 0, 0, 0, 10, 0, 0, C_R, 2'b10));
    // same-cycle write/read of x9, then plain read
    add_vec(32'h00048533, 32'h140, 0, 1, 5'd9, 32'hA5A5_A5A5, 0, ex(32'h140, byp, 0, 0, 9, 0, 10, 0, 0, C_R, 2'b10));
    add_vec(32'h00048533, 32'h144, 0, 0, 0, 0, 0, ex(32'h144, 32'hA5A5_A5A5, 0, 0, 9, 0, 10, 0, 0, C_R, 2'b10));

    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].pc4, vecs[i].flush, vecs[i].wbe, vecs[i].wbrd, vecs[i].wbd);
      #1;
      chk($sformatf("v%0d_pcw", i), {158'd0, bus.pc_write, bus.if_id_write},
          {158'd0, !vecs[i].stall, !vecs[i].stall});
      sb.push_back(vecs[i].exp);
      edge_and_pop($sformatf("v%0d_idex", i));
    end

    // reset asserted mid-stall: ID/EX clears at once, stall drops, regfile wiped
    drive(32'h0000A283, 32'h200, 0, 0, 0, 0);
    sb.push_back(ex(32'h200, 32'h100, 0, 0, 1, 0, 5, 2, 0, C_LD, 2'b00));
    edge_and_pop("rst_lw_idex");
    drive(32'h00228333, 32'h204, 0, 0, 0, 0);
    #1;
    chk("rst_stall_pcw", {158'd0, bus.pc_write, bus.if_id_write}, 160'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid_idex", 160'(got()), 160'(0));
    chk("rst_mid_pcw", {158'd0, bus.pc_write, bus.if_id_write}, 160'd3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(32'h006283B3, 32'h208, 0, 0, 0, 0);
    sb.push_back(ex(32'h208, 0, 0, 0, 5, 6, 7, 0, 0, C_R, 2'b10));
    edge_and_pop("rst_cleared_rf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish want finish by 50000");
    $fatal(1, "timeout");
  end
endmodule
